subsystem_rpstack: RTL and testbench

//  Parametrised return-pointer stack: next generation of the rp adder. Keeps a

---
 rtl/rp_pkg.sv | 19 +
 rtl/rp_lifo_mem.sv | 29 ++
 rtl/subsystem_rpstack.sv | 130 +++++++++++++
 tb/tb_subsystem_rpstack.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rp_pkg.sv
// Shared definitions for the return-pointer stack: opcode encoding and a
// ceil-log2 helper used to size the head and count registers.
package rp_pkg;

  typedef enum logic [1:0] {
    RP_HOLD = 2'd0,
    RP_PUSH = 2'd1,
    RP_POP  = 2'd2,
    RP_LOAD = 2'd3
  } rp_op_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rp_lifo_mem.sv
// Return-address storage: synchronous write, two asynchronous read ports.
// Contents are deliberately left unreset.
`default_nettype none
module rp_lifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  parameter int AW     = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/subsystem_rpstack.sv
// Return-pointer stack: hardware LIFO of return addresses with occupancy
// pointer, registered top-of-stack, and sticky overflow/underflow flags.
`default_nettype none
module subsystem_rpstack
  import rp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int RP_W   = 16,
  parameter int WRAP   = 0
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic [1:0]        rp_op,
  input  logic [DATA_W-1:0] push_data,
  input  logic [RP_W-1:0]   load_val,
  input  logic              clr_err,
  output logic [RP_W-1:0]   rp,
  output logic [DATA_W-1:0] top_data,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0]   C_DEPTH  = CW'(DEPTH);
  localparam logic [RP_W-1:0] LOAD_MAX = RP_W'(DEPTH);

  logic [AW-1:0]     head_q, head_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic              mem_we;
  logic [AW-1:0]     pop_idx, ld_idx;
  logic [DATA_W-1:0] pop_rd, ld_rd;
  logic [CW-1:0]     ld_cnt;
  logic              ld_over, is_full, is_empty, ovf_evt, unf_evt;
  rp_op_e            op;

  assign op       = rp_op_e'(rp_op);
  assign is_full  = (count_q == C_DEPTH);
  assign is_empty = (count_q == '0);
  assign ld_over  = (load_val > LOAD_MAX);
  assign ld_cnt   = ld_over ? C_DEPTH : load_val[CW-1:0];
  // head-2 is the entry that becomes top after a pop (head-1 is being discarded).
  assign pop_idx  = head_q - AW'(2);
  assign ld_idx   = AW'(ld_cnt - CW'(1));

  rp_lifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_mem (
    .clk_i     (CLK),
    .we_i      (mem_we),
    .waddr_i   (head_q),
    .wdata_i   (push_data),
    .raddr_a_i (pop_idx),
    .rdata_a_o (pop_rd),
    .raddr_b_i (ld_idx),
    .rdata_b_o (ld_rd)
  );

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    top_d   = top_q;
    mem_we  = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    case (op)
      RP_PUSH: begin
        ovf_evt = is_full;
        if (!is_full || (WRAP != 0)) begin
          mem_we = 1'b1;
          head_d = head_q + AW'(1);
          top_d  = push_data;
          if (!is_full) count_d = count_q + CW'(1);
        end
      end
      RP_POP: begin
        if (is_empty) begin
          unf_evt = 1'b1;
        end else begin
          head_d  = head_q - AW'(1);
          count_d = count_q - CW'(1);
          top_d   = (count_q == CW'(1)) ? '0 : pop_rd;
        end
      end
      RP_LOAD: begin
        count_d = ld_cnt;
        head_d  = ld_cnt[AW-1:0];
        top_d   = (ld_cnt == '0) ? '0 : ld_rd;
        ovf_evt = ld_over;
      end
      default: ;
    endcase
    // A new error on the same edge as clr_err must still be recorded.
    ovf_d = (ovf_q & ~clr_err) | ovf_evt;
    unf_d = (unf_q & ~clr_err) | unf_evt;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign rp        = RP_W'(count_q);
  assign top_data  = top_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_subsystem_rpstack.sv
// Directed bench for subsystem_rpstack: a saturating and a circular instance
// (DEPTH=4) driven by the same stimulus, each checked against hand values.
`default_nettype none
module tb_subsystem_rpstack;

  localparam int DW = 16;
  localparam int RW = 16;

  logic          CLK = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    rp_op = 2'd0;
  logic [DW-1:0] push_data = '0;
  logic [RW-1:0] load_val = '0;
  logic          clr_err = 1'b0;

  logic [RW-1:0] rp0, rp1;
  logic [DW-1:0] top0, top1;
  logic          emp0, emp1, ful0, ful1, ovf0, ovf1, unf0, unf1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  subsystem_rpstack #(.DATA_W(DW), .DEPTH(4), .RP_W(RW), .WRAP(0)) dut0 (
    .CLK(CLK), .reset_n(reset_n), .rp_op(rp_op), .push_data(push_data),
    .load_val(load_val), .clr_err(clr_err), .rp(rp0), .top_data(top0),
    .empty(emp0), .full(ful0), .overflow(ovf0), .underflow(unf0));

  subsystem_rpstack #(.DATA_W(DW), .DEPTH(4), .RP_W(RW), .WRAP(1)) dut1 (
    .CLK(CLK), .reset_n(reset_n), .rp_op(rp_op), .push_data(push_data),
    .load_val(load_val), .clr_err(clr_err), .rp(rp1), .top_data(top1),
    .empty(emp1), .full(ful1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one op before the edge, then sample just after it.
  task automatic step(input logic [1:0] op, input logic [DW-1:0] d,
                      input logic [RW-1:0] lv, input logic clr);
    @(negedge CLK);
    rp_op = op; push_data = d; load_val = lv; clr_err = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset_n = 1'b0;
    rp_op = 2'd0; clr_err = 1'b0;
    @(negedge CLK);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_rp", rp0, 0);
    chk("rst_top", top0, 0);
    chk("rst_empty", emp0, 1);
    chk("rst_full", ful0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);

    step(2'd1, 16'h10, 0, 0);
    step(2'd1, 16'h20, 0, 0);
    step(2'd1, 16'h30, 0, 0);
    chk("p3_rp", rp0, 3);
    chk("p3_top", top0, 16'h30);
    chk("p3_empty", emp0, 0);
    chk("p3_full", ful0, 0);

    step(2'd1, 16'h40, 0, 0);
    chk("p4_full", ful0, 1);
    chk("p4_ovf", ovf0, 0);
    step(2'd1, 16'h50, 0, 0);
    chk("sat_rp", rp0, 4);
    chk("sat_full", ful0, 1);
    chk("sat_top", top0, 16'h40);
    chk("sat_ovf", ovf0, 1);
    chk("wrap_top", top1, 16'h50);
    chk("wrap_rp", rp1, 4);
    chk("wrap_ovf", ovf1, 1);

    step(2'd2, 0, 0, 0);
    chk("sat_pop_top", top0, 16'h30);
    chk("sat_pop_rp", rp0, 3);
    chk("wrap_pop_top", top1, 16'h40);

    // Circular-mode sequence: push 1..5 then pop four times.
    do_reset();
    for (int i = 1; i <= 5; i++) step(2'd1, DW'(i), 0, 0);
    step(2'd2, 0, 0, 0);
    chk("w_pop1", top1, 16'h4);
    chk("s_pop1", top0, 16'h3);
    step(2'd2, 0, 0, 0);
    chk("w_pop2", top1, 16'h3);
    chk("s_pop2", top0, 16'h2);
    step(2'd2, 0, 0, 0);
    chk("w_pop3", top1, 16'h2);
    chk("s_pop3", top0, 16'h1);
    step(2'd2, 0, 0, 0);
    chk("w_pop4", top1, 16'h0);
    chk("w_rp_end", rp1, 0);
    chk("w_ovf_end", ovf1, 1);
    chk("s_rp_end", rp0, 0);

    step(2'd2, 0, 0, 0);
    chk("unf_rp", rp0, 0);
    chk("unf_set", unf0, 1);
    chk("unf_set_w", unf1, 1);
    step(2'd0, 0, 0, 1);
    chk("unf_clr", unf0, 0);
    chk("ovf_clr", ovf0, 0);
    step(2'd2, 0, 0, 1);
    chk("unf_clr_vs_evt", unf0, 1);

    step(2'd0, 0, 0, 1);
    step(2'd1, 16'hA, 0, 0);
    step(2'd1, 16'hB, 0, 0);
    step(2'd1, 16'hC, 0, 0);
    step(2'd3, 0, 16'd1, 0);
    chk("ld1_rp", rp0, 1);
    chk("ld1_top", top0, 16'hA);
    chk("ld1_ovf", ovf0, 0);
    step(2'd3, 0, 16'd9, 0);
    chk("ld9_rp", rp0, 4);
    chk("ld9_ovf", ovf0, 1);
    chk("ld9_top", top0, 16'h4);
    chk("ld9_full", ful0, 1);
    step(2'd3, 0, 16'd0, 0);
    chk("ld0_rp", rp0, 0);
    chk("ld0_top", top0, 0);
    chk("ld0_empty", emp0, 1);

    step(2'd1, 16'h77, 0, 0);
    chk("pre_async_rp", rp0, 1);
    // Drop reset between edges while a push is pending.
    @(negedge CLK);
    rp_op = 2'd1; push_data = 16'h99;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rp", rp0, 0);
    chk("async_ovf", ovf0, 0);
    chk("async_unf", unf0, 0);
    chk("async_top", top0, 0);
    chk("async_empty", emp0, 1);
    @(negedge CLK);
    rp_op = 2'd0;
    reset_n = 1'b1;
    step(2'd0, 0, 0, 0);
    chk("hold_rp", rp0, 0);
    chk("hold_top", top0, 0);
    chk("hold_ovf", ovf0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
